load_store_unit: RTL
====================

# load_store_unit

Sequencer between the execute stage and the word-addressed data memory. It accepts one byte, halfword or word load/store request at a time and converts the byte address into a word index. Loads come back sign- or zero-extended; sub-word stores are done as read-modify-write, because the memory has no byte enables. It absorbs the memory's one-cycle registered read latency and flags misaligned accesses without touching memory.

## Interface
- ADDRSIZE, 5, memory word-index width (memory holds 2^ADDRSIZE words)
- WORDSIZE, 32, data width; fixed at 32 for this block
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned/illegal request; valid with resp_valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_read  out  1  to memory memRead
- mem_write  out  1  to memory memWrite
- mem_addr  out  ADDRSIZE  to memory address; equals req_addr[ADDRSIZE+1:2]
- mem_wdata  out  32  to memory writeData
- mem_rdata  in  32  from memory readData; valid the cycle after a mem_read edge

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, capture req_write, req_size, req_unsigned, req_addr and req_wdata at the edge.
  - Next state:
    - RESP with error set, if size 11, halfword with addr[0]=1, or word with addr[1:0]≠0.
    - WR for a word store.
    - RD otherwise (any load, byte store, halfword store).
- RD: mem_read=1 for exactly one cycle → WAIT.
- WAIT: mem_rdata valid.
  - Load: extract the lane, extend it, register it into resp_rdata → RESP.
  - Sub-word store: merge the store data into the read word, register the merged word → WR.
- Lane extraction:
  - Byte: bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Halfword: bits [16*addr[1]+15 : 16*addr[1]].
  - Little-endian.
- Merge: replace only the addressed byte/halfword lane with req_wdata[7:0] / [15:0]; all other bits keep the value read.
- WR: mem_write=1 for one cycle with mem_wdata = full word or merged word → RESP.
- RESP: resp_valid=1 for one cycle → IDLE. No response backpressure.
- mem_read and mem_write are never both 1.
- mem_addr is held from the captured address in every non-IDLE state.
- Address bits above ADDRSIZE+1 are ignored, so addresses wrap modulo 4·2^ADDRSIZE.

## Timing
- Reset (rst_n=0 at an edge):
  - State → IDLE; any in-flight request is dropped.
  - Outputs:
    - resp_valid=0, resp_err=0, resp_rdata=0.
    - mem_read=0, mem_write=0.
    - mem_addr=0, mem_wdata=0.
    - req_ready=1 after the reset edge.
  - No memory write is issued after reset, even if asserted mid-RMW. Memory contents are untouched.
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - Load: 4 cycles (RD, WAIT, RESP).
  - Word store: 3 cycles.
  - Sub-word store: 5 cycles.
  - Error: 2 cycles.
- Throughput: at most one outstanding request. req_ready=0 from the cycle after accept until IDLE is re-entered, i.e. the cycle after the resp_valid pulse.
- All outputs are driven from registered state/capture registers only; no combinational path from req_* to mem_*.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum (IDLE, RD, WAIT, WR, RESP);
  - the misalignment check function.
- One combinational sub-module, lsu_align: inputs word, addr[1:0], size, unsigned, wdata; outputs the extended load value and the merged store word. The FSM and capture registers stay in load_store_unit.

## Test plan
- Word load: memory word 3 = 0x8899AABB; load word at 0x0C → resp_rdata=0x8899AABB, resp_err=0, resp_valid 4 cycles after accept.
- Signed/unsigned byte: word 3 = 0x8899AABB.
  - Signed byte at 0x0D → 0xFFFFFFAA.
  - Unsigned byte at 0x0D → 0x000000AA.
  - Signed half at 0x0E → 0xFFFF8899.
- RMW: word 2 = 0x11223344; byte store 0xEE at 0x09.
  - Exactly one mem_read then one mem_write, 0x1122EE44.
  - A following word load at 0x08 returns 0x1122EE44.
- Misalign: halfword load at 0x03 and word store at 0x06 → resp_err=1 after 2 cycles, resp_rdata=0, mem_read and mem_write never asserted.
- Wrap and reset (ADDRSIZE=5):
  - Word store 0xCAFEF00D at 0x80 → lands in word 0.
  - A halfword store accepted, then rst_n=0 during WAIT → no mem_write, req_ready=1 after reset, word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the alignment rule for the load/store unit.
// Combinational helpers only; no latency and no backpressure.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_t;

  // Size 11 is never legal; halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake and word-memory bus of the load/store unit.
// The unit side uses modport slave; the execute stage and memory use master.
interface lsu_if #(
  parameter int ADDRSIZE = 5
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;

  logic                resp_valid;
  logic                resp_err;
  logic [31:0]         resp_rdata;

  logic                mem_read;
  logic                mem_write;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, lane merge for sub-word stores.
// Purely combinational: zero latency, no backpressure.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  byte_sel;
  logic [4:0]  half_sel;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Little-endian: byte 0 sits in bits [7:0].
  assign byte_sel = {addr, 3'b000};
  assign half_sel = {addr[1], 4'b0000};
  assign lane_b   = word[byte_sel +: 8];
  assign lane_h   = word[half_sel +: 16];

  always_comb begin
    load_val = word;
    case (size)
      SZ_BYTE: load_val = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_val = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[byte_sel +: 8]  = wdata[7:0];
      SZ_HALF: merged[half_sel +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences byte/half/word loads and stores onto a word memory, RMW for sub-word stores.
// Latency accept->resp: error 2, word store 3, load 4, sub-word store 5; req_ready low while busy.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 32
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  state_t                state;
  state_t                state_n;

  logic                  write_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDRSIZE+1:0]   addr_q;
  logic [WORDSIZE-1:0]   wdata_q;
  logic [WORDSIZE-1:0]   rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_bad;
  logic [WORDSIZE-1:0]   load_val;
  logic [WORDSIZE-1:0]   merged;
  logic                  unused_addr_hi;

  // Byte address bits above the memory's reach are dropped so addresses wrap.
  assign unused_addr_hi = ^bus.req_addr[31:ADDRSIZE+2];

  assign accept  = (state == IDLE) && bus.req_valid;
  assign req_bad = misaligned(bus.req_size, bus.req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad)                                       state_n = RESP;
          else if (bus.req_write && bus.req_size == SZ_WORD) state_n = WR;
          else                                               state_n = RD;
        end
      end
      RD:      state_n = WAIT;
      WAIT:    state_n = write_q ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= bus.req_write;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr[ADDRSIZE+1:0];
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
      err_q   <= req_bad;
    end else if (state == WAIT) begin
      // wdata_q is reused to hold the merged word for the following WR cycle.
      if (write_q) wdata_q <= merged;
      else         rdata_q <= load_val;
    end
  end

  lsu_align u_align (
    .word        (bus.mem_rdata),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_read   = (state == RD);
  assign bus.mem_write  = (state == WR);
  assign bus.mem_addr   = addr_q[ADDRSIZE+1:2];
  assign bus.mem_wdata  = wdata_q;

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mem_read && bus.mem_write));
  a_err_no_mem: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESP && err_q) |-> !(bus.mem_read || bus.mem_write));

endmodule
